// File: rtl/mdu_hilo_pkg.sv
// rtl/mdu_hilo_pkg.sv - shared MDU operation codes and FSM state codes
package mdu_hilo_pkg;

   typedef enum logic [2:0] {
      MDU_OP_NOP   = 3'd0,
      MDU_OP_MULT  = 3'd1,
      MDU_OP_MULTU = 3'd2,
      MDU_OP_DIV   = 3'd3,
      MDU_OP_DIVU  = 3'd4,
      MDU_OP_MTHI  = 3'd5,
      MDU_OP_MTLO  = 3'd6
   } mdu_op_e;

   typedef enum logic [1:0] {
      MDU_S_IDLE = 2'd0,
      MDU_S_CALC = 2'd1,
      MDU_S_FIX  = 2'd2
   } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - applies signed-result correction and divide-by-zero override
module mdu_sign_fix
   import mdu_hilo_pkg::*;
(
   input  logic [63:0] raw,
   input  logic [2:0]  op,
   input  logic        sign_a,
   input  logic        sign_b,
   input  logic        div0,
   input  logic [31:0] a,
   output logic [63:0] res
);

   always_comb begin
      res = raw;
      case (op)
         MDU_OP_MULT: if (sign_a ^ sign_b) res = -raw;
         MDU_OP_DIV: begin
            res[31:0]  = (sign_a ^ sign_b) ? -raw[31:0] : raw[31:0];
            res[63:32] = sign_a ? -raw[63:32] : raw[63:32];
         end
         default: res = raw;
      endcase
      // A zero divisor yields a fixed pattern regardless of operand signs
      if (div0 && (op == MDU_OP_DIV || op == MDU_OP_DIVU))
         res = {a, 32'hFFFF_FFFF};
   end

endmodule

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - iterative multiply/divide unit with HI/LO registers
// MDU_FAST_MUL_EN: multiplies complete in one cycle without asserting busy
module mdu_hilo
   import mdu_hilo_pkg::*;
#(
   parameter int ITER = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  mdu_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CW = $clog2(ITER);

   mdu_state_e    state, state_n;
   logic [CW-1:0] cnt;
   logic [63:0]   acc, acc_mul, acc_div, fixed;
   logic [31:0]   opnd, a_q, mag_a, mag_b;
   logic [2:0]    op_q;
   logic          sign_a, sign_b, div0;
   logic          is_mul, is_div, is_signed, accept, mul_q;
   logic [32:0]   sum, trial, diff;

   assign accept    = (state == MDU_S_IDLE) && start;
   assign is_mul    = (mdu_op == MDU_OP_MULT) || (mdu_op == MDU_OP_MULTU);
   assign is_div    = (mdu_op == MDU_OP_DIV)  || (mdu_op == MDU_OP_DIVU);
   assign is_signed = (mdu_op == MDU_OP_MULT) || (mdu_op == MDU_OP_DIV);
   assign mag_a     = (is_signed && A[31]) ? -A : A;
   assign mag_b     = (is_signed && B[31]) ? -B : B;
   assign mul_q     = (op_q == MDU_OP_MULT) || (op_q == MDU_OP_MULTU);

   // Shift-add step: acc holds {partial product, remaining multiplier bits}
   assign sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
   assign acc_mul = {sum, acc[31:1]};

   // Restoring step: acc holds {remainder, dividend bits shifting into quotient}
   assign trial   = {acc[63:32], acc[31]};
   assign diff    = trial - {1'b0, opnd};
   assign acc_div = diff[32] ? {trial[31:0], acc[30:0], 1'b0}
                             : {diff[31:0], acc[30:0], 1'b1};

`ifdef MDU_FAST_MUL_EN
   assign busy = (state == MDU_S_CALC) || (state == MDU_S_FIX && !mul_q);
`else
   assign busy = (state != MDU_S_IDLE);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= MDU_S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         MDU_S_IDLE: begin
`ifdef MDU_FAST_MUL_EN
            if (accept && is_mul)      state_n = MDU_S_FIX;
            else if (accept && is_div) state_n = MDU_S_CALC;
`else
            if (accept && (is_mul || is_div)) state_n = MDU_S_CALC;
`endif
         end
         MDU_S_CALC: if (cnt == CW'(ITER - 1)) state_n = MDU_S_FIX;
         MDU_S_FIX:  state_n = MDU_S_IDLE;
         default:    state_n = MDU_S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         acc    <= '0;
         opnd   <= '0;
         a_q    <= '0;
         op_q   <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         div0   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            MDU_S_IDLE: if (accept) begin
               if (mdu_op == MDU_OP_MTHI) hi <= A;
               if (mdu_op == MDU_OP_MTLO) lo <= A;
               if (is_mul || is_div) begin
                  cnt    <= '0;
                  op_q   <= mdu_op;
                  a_q    <= A;
                  sign_a <= A[31];
                  sign_b <= B[31];
                  div0   <= (B == 32'd0);
               end
               if (is_mul) begin
                  opnd <= mag_a;
`ifdef MDU_FAST_MUL_EN
                  acc  <= {32'd0, mag_a} * {32'd0, mag_b};
`else
                  acc  <= {32'd0, mag_b};
`endif
               end
               if (is_div) begin
                  opnd <= mag_b;
                  acc  <= {32'd0, mag_a};
               end
            end
            MDU_S_CALC: begin
               cnt <= cnt + 1'b1;
               acc <= mul_q ? acc_mul : acc_div;
            end
            MDU_S_FIX: begin
               {hi, lo} <= fixed;
               done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   mdu_sign_fix u_sign_fix (
      .raw    (acc),
      .op     (op_q),
      .sign_a (sign_a),
      .sign_b (sign_b),
      .div0   (div0),
      .a      (a_q),
      .res    (fixed)
   );

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - self-checking bench for mdu_hilo
module tb_mdu_hilo;
   import mdu_hilo_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  mdu_op = 3'd0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   mdu_hilo dut (
      .clk(clk), .rst(rst), .start(start), .mdu_op(mdu_op),
      .A(A), .B(B), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sp;
      logic signed [31:0] sa, sb, q, r;
      sa = a;
      sb = b;
      case (op)
         MDU_OP_MULTU: return {32'd0, a} * {32'd0, b};
         MDU_OP_MULT: begin
            sp = 64'(sa) * 64'(sb);
            return sp;
         end
         MDU_OP_DIVU: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         MDU_OP_DIV: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = sa / sb;
            r = sa % sb;
            return {r, q};
         end
         default: return 64'd0;
      endcase
   endfunction

   // Issues one op, optionally injects an MTLO while busy, checks timing and result
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input bit inject);
      logic [31:0] hi0, lo0;
      int n;
      bit got, hold_ok;
      hi0 = hi;
      lo0 = lo;
      @(negedge clk);
      start = 1'b1; mdu_op = op; A = a; B = b;
      @(negedge clk);
      start = 1'b0; A = $urandom; B = $urandom;
      n = 0; got = 0; hold_ok = 1;
      for (int i = 0; i < 50 && !got; i++) begin
         if (done) got = 1;
         else begin
            if (busy) n++;
            if (hi !== hi0 || lo !== lo0) hold_ok = 0;
            if (inject && i == 5) begin
               start = 1'b1; mdu_op = MDU_OP_MTLO; A = 32'hDEAD_BEEF;
            end else start = 1'b0;
            @(negedge clk);
         end
      end
      start = 1'b0;
      chk({tag, "_done"}, 64'(got), 64'd1);
      chk({tag, "_busycyc"}, 64'(n), 64'd33);
      chk({tag, "_busy0"}, 64'(busy), 64'd0);
      chk({tag, "_hold"}, 64'(hold_ok), 64'd1);
      chk({tag, "_hilo"}, {hi, lo}, exp);
      @(negedge clk);
      chk({tag, "_pulse"}, 64'(done), 64'd0);
   endtask

   task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] a);
      logic [31:0] hi0, lo0;
      hi0 = hi;
      lo0 = lo;
      @(negedge clk);
      start = 1'b1; mdu_op = op; A = a;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_val"}, {hi, lo}, (op == MDU_OP_MTHI) ? {a, lo0} : {hi0, a});
      chk({tag, "_busy"}, {63'd0, busy | done}, 64'd0);
   endtask

   initial begin
      logic [2:0] rop;
      logic [31:0] ra, rb;
      bit saw_done;

      repeat (3) @(negedge clk);
      chk("reset_state", {busy, done, hi, lo}, 66'd0);
      rst = 1'b0;

      run_mt("mthi", MDU_OP_MTHI, 32'h1234_5678);
      run_mt("mtlo", MDU_OP_MTLO, 32'h9ABC_DEF0);

      @(negedge clk);
      start = 1'b1; mdu_op = MDU_OP_NOP; A = 32'h5555_5555;
      @(negedge clk);
      start = 1'b0;
      chk("nop", {busy, done, hi, lo}, {2'b00, 32'h1234_5678, 32'h9ABC_DEF0});

      run_op("multu_max", MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 0);
      run_op("mult_neg",  MDU_OP_MULT,  32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, 0);
      run_op("div_neg",   MDU_OP_DIV,   32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
      run_op("div_ovf",   MDU_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0);
      run_op("divu_zero", MDU_OP_DIVU,  32'd100, 32'd0, {32'h0000_0064, 32'hFFFF_FFFF}, 0);
      run_op("div_zero",  MDU_OP_DIV,   32'hFFFF_FF00, 32'd0, {32'hFFFF_FF00, 32'hFFFF_FFFF}, 0);
      run_op("mtlo_busy", MDU_OP_DIVU,  32'd1000, 32'd7, {32'd6, 32'd142}, 1);

      // Reset in the middle of a divide must abort it without a done pulse
      @(negedge clk);
      start = 1'b1; mdu_op = MDU_OP_DIVU; A = 32'd12345; B = 32'd67;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("rst_mid", {busy, done, hi, lo}, 66'd0);
      @(negedge clk);
      rst = 1'b0;
      saw_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) saw_done = 1;
      end
      chk("rst_quiet", 64'(saw_done), 64'd0);
      run_op("after_rst", MDU_OP_DIVU, 32'd12345, 32'd67, {32'd17, 32'd184}, 0);

      for (int i = 0; i < 20; i++) begin
         rop = 3'($urandom_range(1, 4));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 15));
            2: ra = 32'h8000_0000;
            3: rb = 32'hFFFF_FFFF;
            default: ;
         endcase
         run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
